// File: rtl/pipe_stage_reg_chain.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_chain : DEPTH-stage valid/payload pipeline register with
// freeze/flush control and saturating stall/flush counters.   Rev 1.0
// ============================================================================
module pipe_stage_reg_chain #(
   parameter int DATA_W        = 126,
   parameter int DEPTH         = 1,
   parameter int FLUSH_PRIO    = 0,
   parameter int ZERO_ON_FLUSH = 1,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic [DEPTH-1:0]  stage_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [DEPTH-1:0][DATA_W-1:0] data_q;
   logic [DEPTH-1:0]             valid_q;
   logic                         hold;
   logic                         kill;

   // One action for the whole chain; priority resolves freeze+flush overlap.
   generate
      if (FLUSH_PRIO != 0) begin : g_flush_first
         assign kill = flush;
         assign hold = freeze & ~flush;
      end else begin : g_freeze_first
         assign hold = freeze;
         assign kill = flush & ~freeze;
      end
   endgenerate

   // Input prepended below the stage registers; the low DEPTH entries form
   // the shifted image, which also covers DEPTH=1 without special casing.
   logic [DEPTH:0][DATA_W-1:0] data_ext;
   logic [DEPTH:0]             valid_ext;
   assign data_ext  = {data_q, data_in};
   assign valid_ext = {valid_q, valid_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= '0;
      end else if (hold) begin
         data_q  <= data_q;
         valid_q <= valid_q;
      end else if (kill) begin
         valid_q <= '0;
         if (ZERO_ON_FLUSH != 0) begin
            data_q <= '0;
         end
      end else begin
         data_q  <= data_ext[DEPTH-1:0];
         valid_q <= valid_ext[DEPTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hold && busy && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (kill && busy && (flush_cnt != {CNT_W{1'b1}})) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

   assign valid_out   = valid_q[DEPTH-1];
   assign data_out    = data_q[DEPTH-1];
   assign stage_valid = valid_q;
   assign busy        = |valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg_chain.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg_chain : two DEPTH=3 instances (freeze-first/zeroing/4-bit
// counters and flush-first/non-zeroing) against a queue scoreboard.  Rev 1.0
// ============================================================================
module tb_pipe_stage_reg_chain;

   logic       clk = 1'b0;
   logic       rst, freeze, flush, valid_in;
   logic [7:0] data_in;

   logic       va, vb, ba, bb;
   logic [7:0] da, db;
   logic [2:0] sva, svb;
   logic [3:0] sta, fca;
   logic [15:0] stb, fcb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_reg_chain #(.DATA_W(8), .DEPTH(3), .FLUSH_PRIO(0),
                          .ZERO_ON_FLUSH(1), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(va), .data_out(da), .stage_valid(sva), .busy(ba),
      .stall_cnt(sta), .flush_cnt(fca));

   pipe_stage_reg_chain #(.DATA_W(8), .DEPTH(3), .FLUSH_PRIO(1),
                          .ZERO_ON_FLUSH(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .valid_in(valid_in), .data_in(data_in),
      .valid_out(vb), .data_out(db), .stage_valid(svb), .busy(bb),
      .stall_cnt(stb), .flush_cnt(fcb));

   typedef struct {
      logic [2:0]      v;
      logic [2:0][7:0] d;
      int              st;
      int              fc;
   } mstate_t;

   typedef struct {
      logic       r, fz, fl, vin;
      logic [7:0] din;
      logic       vout;
      logic [7:0] dout;
      logic [2:0] sv;
      int         st, fc;
   } vec_t;

   mstate_t ma, mb;
   mstate_t qa[$], qb[$];
   vec_t    tbl[$];

   function automatic mstate_t step(mstate_t m, bit fp, bit zof, int cmax,
                                    bit r, bit fz, bit fl, bit vin,
                                    logic [7:0] din);
      mstate_t n = m;
      bit busy_m = |m.v;
      bit hold_m, kill_m;
      if (r) begin
         n.v = '0; n.d = '0; n.st = 0; n.fc = 0;
         return n;
      end
      hold_m = fp ? (fz && !fl) : fz;
      kill_m = fp ? fl : (fl && !fz);
      if (hold_m) begin
         if (busy_m && n.st < cmax) n.st++;
      end else if (kill_m) begin
         n.v = '0;
         if (zof) n.d = '0;
         if (busy_m && n.fc < cmax) n.fc++;
      end else begin
         n.v    = {m.v[1:0], vin};
         n.d[2] = m.d[1];
         n.d[1] = m.d[0];
         n.d[0] = din;
      end
      return n;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic cycle(input logic r, input logic fz, input logic fl,
                        input logic vin, input logic [7:0] din);
      mstate_t ea, eb;
      @(negedge clk);
      rst = r; freeze = fz; flush = fl; valid_in = vin; data_in = din;
      ma = step(ma, 1'b0, 1'b1, 15,    r === 1'b1, fz === 1'b1, fl === 1'b1, vin, din);
      mb = step(mb, 1'b1, 1'b0, 65535, r === 1'b1, fz === 1'b1, fl === 1'b1, vin, din);
      qa.push_back(ma);
      qb.push_back(mb);
      @(posedge clk);
      #1;
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_valid_out", int'(va), int'(ea.v[2]));
      chk("a_data_out",  int'(da), int'(ea.d[2]));
      chk("a_stage_valid", int'(sva), int'(ea.v));
      chk("a_busy",      int'(ba), int'(|ea.v));
      chk("a_stall_cnt", int'(sta), ea.st);
      chk("a_flush_cnt", int'(fca), ea.fc);
      chk("b_valid_out", int'(vb), int'(eb.v[2]));
      chk("b_data_out",  int'(db), int'(eb.d[2]));
      chk("b_stage_valid", int'(svb), int'(eb.v));
      chk("b_stall_cnt", int'(stb), eb.st);
      chk("b_flush_cnt", int'(fcb), eb.fc);
   endtask

   function automatic void add(logic r, logic fz, logic fl, logic vin,
                               logic [7:0] din, logic vout, logic [7:0] dout,
                               logic [2:0] sv, int st, int fc);
      vec_t t;
      t.r = r; t.fz = fz; t.fl = fl; t.vin = vin; t.din = din;
      t.vout = vout; t.dout = dout; t.sv = sv; t.st = st; t.fc = fc;
      tbl.push_back(t);
   endfunction

   initial begin
      #20000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ma = '{v: '0, d: '0, st: 0, fc: 0};
      mb = ma;
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0;

      // Expected values below are for dut_a (freeze-first, zeroing, CNT_W=4).
      add(1,0,0,0,8'h00, 0,8'h00,3'b000, 0,0);
      add(1,0,0,0,8'h00, 0,8'h00,3'b000, 0,0);
      add(0,0,0,1,8'h11, 0,8'h00,3'b001, 0,0);
      add(0,0,0,1,8'h22, 0,8'h00,3'b011, 0,0);
      add(0,0,0,1,8'h33, 1,8'h11,3'b111, 0,0);
      add(0,0,0,0,8'h00, 1,8'h22,3'b110, 0,0);
      add(0,0,0,0,8'h00, 1,8'h33,3'b100, 0,0);
      add(0,0,0,0,8'h00, 0,8'h00,3'b000, 0,0);
      add(0,0,0,1,8'h44, 0,8'h00,3'b001, 0,0);
      add(0,0,0,0,8'h00, 0,8'h00,3'b010, 0,0);
      for (int i = 1; i <= 4; i++) add(0,1,0,1,8'h99, 0,8'h00,3'b010, i,0);
      add(0,0,0,0,8'h00, 1,8'h44,3'b100, 4,0);
      add(0,0,0,0,8'h00, 0,8'h00,3'b000, 4,0);
      add(0,0,0,1,8'hAA, 0,8'h00,3'b001, 4,0);
      add(0,0,0,1,8'hBB, 0,8'h00,3'b011, 4,0);
      add(0,0,1,1,8'hCC, 0,8'h00,3'b000, 4,1);
      add(0,0,1,0,8'h00, 0,8'h00,3'b000, 4,1);
      add(0,0,0,1,8'hDD, 0,8'h00,3'b001, 4,1);
      add(0,1,1,1,8'hEE, 0,8'h00,3'b001, 5,1);
      for (int i = 0; i < 12; i++)
         add(0,1,0,1,8'h99, 0,8'h00,3'b001, (6 + i > 15) ? 15 : 6 + i, 1);
      add(1,1,0,1,8'h99, 0,8'h00,3'b000, 0,0);
      add(1,1'bx,1'bx,1,8'h99, 0,8'h00,3'b000, 0,0);
      add(0,0,0,1,8'hEE, 0,8'h00,3'b001, 0,0);

      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].fz, tbl[i].fl, tbl[i].vin, tbl[i].din);
         chk("tbl_vout",  int'(va),  int'(tbl[i].vout));
         chk("tbl_dout",  int'(da),  int'(tbl[i].dout));
         chk("tbl_sv",    int'(sva), int'(tbl[i].sv));
         chk("tbl_stall", int'(sta), tbl[i].st);
         chk("tbl_flush", int'(fca), tbl[i].fc);
      end

      // Non-zeroing flush on dut_b: valid drops, last payload stays.
      cycle(0,0,0,1,8'h5A);
      cycle(0,0,0,0,8'h00);
      cycle(0,0,0,0,8'h00);
      chk("b_5a_vout", int'(vb), 1);
      chk("b_5a_dout", int'(db), 8'h5A);
      cycle(0,0,1,0,8'h00);
      chk("b_noz_vout", int'(vb), 0);
      chk("b_noz_dout", int'(db), 8'h5A);
      chk("a_zero_dout", int'(da), 8'h00);

      // Simultaneous freeze+flush: dut_a holds, dut_b kills.
      cycle(0,0,0,1,8'h77);
      cycle(0,1,1,0,8'h00);
      chk("a_ff_sv",    int'(sva), 3'b001);
      chk("a_ff_stall", int'(sta), 1);
      chk("a_ff_flush", int'(fca), 1);
      chk("b_ff_sv",    int'(svb), 3'b000);
      chk("b_ff_flush", int'(fcb), 2);
      chk("b_ff_stall", int'(stb), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg_chain.md
Name: pipe_stage_reg_chain

Overview:
- Parametrised successor to the single-stage ID/EX pipeline register.
- Moves a packed control+data payload through DEPTH back-to-back pipeline stages, each with its own valid bit.
- Supports freeze (stall) and flush (bubble injection), with selectable freeze/flush priority and optional payload zeroing on flush.
- Provides saturating stall/flush performance counters for the hazard/forwarding unit and debug; sits between any two pipeline stages (ID->EXE, EXE->MEM).

Parameters:
DATA_W, 126, payload width in bits (packed control fields, PC, operand values, src/dest regs)
DEPTH, 1, number of register stages; legal range 1..8
FLUSH_PRIO, 0, 0 = freeze beats flush (legacy ordering); 1 = flush beats freeze
ZERO_ON_FLUSH, 1, 1 = flushed stages load all-zero payload; 0 = only valid cleared, payload held
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  hold every stage's contents this cycle
flush  in  1  kill every stage's contents this cycle
valid_in  in  1  payload on data_in is a real instruction
data_in  in  DATA_W  payload from upstream stage
valid_out  out  1  valid bit of last stage
data_out  out  DATA_W  payload of last stage
stage_valid  out  DEPTH  valid bit of each stage; bit 0 = first stage
busy  out  1  OR of stage_valid
stall_cnt  out  CNT_W  cycles with freeze effective while busy=1, saturating
flush_cnt  out  CNT_W  flush events that killed at least one valid stage, saturating

Behaviour:
- Reset: synchronous only, sampled on the rising clk edge while rst=1. Clears all stage payloads to 0, all valid bits to 0, stall_cnt=0, flush_cnt=0. rst overrides freeze and flush. After reset: valid_out=0, data_out=0, busy=0.
- Per-cycle action, evaluated after reset (one action for the whole chain):
  - FLUSH_PRIO=0: freeze -> HOLD; else flush -> KILL; else SHIFT.
  - FLUSH_PRIO=1: flush -> KILL; else freeze -> HOLD; else SHIFT.
- HOLD: every stage keeps payload and valid; valid_in/data_in are dropped. Upstream must also freeze.
- KILL: every stage valid<=0. Payload<=0 if ZERO_ON_FLUSH=1; otherwise payload held. The incoming data_in is also discarded.
- SHIFT: stage0 <= {valid_in, data_in}; stage k <= stage k-1 for k=1..DEPTH-1. Invalid payloads are shifted unchanged; no compaction or bubble collapsing.
- Latency: data_in appears on data_out exactly DEPTH SHIFT cycles after capture; HOLD cycles extend latency one-for-one.
- DEPTH=1 with FLUSH_PRIO=0, ZERO_ON_FLUSH=1 is cycle-identical to the legacy single-stage register, with valid_out tracking the capture.
- Outputs are direct register outputs; no combinational path from any input to any output.
- stall_cnt: +1 on each HOLD cycle where busy=1 before the edge. Stops at 2^CNT_W-1 with no wrap.
- flush_cnt: +1 on each KILL cycle where busy=1 before the edge. Saturates the same way. A KILL on an empty chain does not count.
- freeze and flush asserted together:
  - FLUSH_PRIO=0: HOLD; the flush is lost and only stall_cnt may count.
  - FLUSH_PRIO=1: KILL; only flush_cnt may count.
- Reset asserted mid-freeze or mid-flush: reset wins and counters clear. First SHIFT occurs on the first edge with rst=0 and no freeze/flush.
- X on freeze/flush while rst=1 must not propagate into state.

Test Plan:
- Reset/latency (DEPTH=3): rst 2 cycles, then valid_in=1 with data_in=0x11,0x22,0x33 on consecutive cycles -> valid_out=1, data_out=0x11 on 3rd edge after first capture, then 0x22, 0x33; stage_valid=3'b111, busy=1.
- Freeze (DEPTH=3): after 0x11 reaches stage 1, freeze for 4 cycles -> stage contents unchanged, data_out=0x11 arrives 4 cycles late, stall_cnt=4, data_in offered during freeze never appears.
- Flush with zeroing (ZERO_ON_FLUSH=1): chain holds 0xAA,0xBB, assert flush 1 cycle -> stage_valid=0, data_out=0, busy=0, flush_cnt=1; second flush on empty chain -> flush_cnt stays 1.
- Simultaneous freeze+flush: FLUSH_PRIO=0 -> contents held, stall_cnt+1, flush_cnt unchanged. FLUSH_PRIO=1 -> all valid cleared, flush_cnt+1, stall_cnt unchanged.
- Counter saturation (CNT_W=4): chain valid, freeze 20 cycles -> stall_cnt stops at 15. Then rst for 1 cycle during freeze -> stall_cnt=0, stage_valid=0.
- ZERO_ON_FLUSH=0: chain holds 0x5A in last stage, flush -> valid_out=0, data_out stays 0x5A.
